sobel_frame_ctrl: RTL and testbench
===================================

# sobel_frame_ctrl

Raster-scan frame controller that sequences a pixel stream into the Sobel datapath. It accepts one pixel per handshake and keeps two line buffers plus a 3×3 shift window. For every interior pixel position it emits one registered 3×3 window, with coordinates and a last-window flag. It sits between the camera/DMA pixel source and `sobel_operator`, owns frame start, done and abort, and applies backpressure to the source when the datapath stalls.

## Interface
- `IMG_W`, 640, pixels per line (≥3)
- `IMG_H`, 480, lines per frame (≥3)
- `PIX_W`, 8, bits per pixel
- `clk  in  1  system clock`
- `rst_n  in  1  asynchronous reset, active-high (asserted = 1); one clock; asynchronous active-high reset`
- `start  in  1  pulse: begin a frame (honoured only in IDLE)`
- `abort  in  1  pulse: terminate current frame`
- `s_valid  in  1  source pixel valid`
- `s_ready  out  1  controller can accept pixel`
- `s_data  in  PIX_W  source pixel, raster order`
- `m_valid  out  1  window valid`
- `m_ready  in  1  datapath accepts window`
- `m_win  out  9*PIX_W  window; element k=row*3+col at [k*PIX_W +: PIX_W], row 0 = oldest line, col 0 = leftmost`
- `m_x  out  clog2(IMG_W)  centre column of window`
- `m_y  out  clog2(IMG_H)  centre row of window`
- `m_last  out  1  final window of frame`
- `busy  out  1  state ≠ IDLE`
- `done  out  1  one-cycle pulse at frame completion`

## Operation
- States: IDLE, ACTIVE, FLUSH.
  - IDLE → ACTIVE on `start`. Column and row counters clear. Window registers are not cleared.
  - ACTIVE → FLUSH when pixel (IMG_H-1, IMG_W-1) is accepted.
  - FLUSH → IDLE when the `m_last` window handshakes. `done` pulses in the same cycle as that transition.
  - Any state → IDLE on `abort`. The pending window is dropped. `done` is not pulsed.
- Accept rule: pixel accepted ⇔ `s_valid && s_ready`. `s_ready` = (state==ACTIVE) && (!m_valid || m_ready).
- Per accepted pixel at (r,c):
  - Read the line buffers at column c: LB1 holds row r-1, LB0 holds row r-2.
  - Write `s_data` into LB1[c] and the old LB1[c] into LB0[c]. Read happens before write.
  - Shift the 3×3 window left by one column. The new right column is {LB0[c], LB1[c], s_data}.
- Window emission: if r≥2 && c≥2, load the output register with m_valid=1, m_x=c-1, m_y=r-1, and m_last=(r==IMG_H-1 && c==IMG_W-1).
  - Border pixels are never emitted. A frame yields (IMG_W-2)·(IMG_H-2) windows.
- Counters: c wraps IMG_W-1 → 0 and increments r. r never exceeds IMG_H-1.
- `m_valid` holds with stable payload until `m_ready`. It clears on handshake unless a new window loads in the same cycle.
- `start` in ACTIVE or FLUSH is ignored. If `start` and `abort` arrive in the same cycle, `abort` wins.
- Widths: coordinates are unsigned, with width clog2 of the dimension. Window data is raw pixels with no arithmetic.

## Timing
- Reset values: state=IDLE, s_ready=0, m_valid=0, m_win=0, m_x=0, m_y=0, m_last=0, busy=0, done=0. Line buffer contents are undefined and never observed before being written.
- Latency: a window appears on `m_*` one cycle after the handshake of its bottom-right pixel.
- Throughput: one pixel and one window per cycle when `m_ready` is held at 1.
- Backpressure: `m_ready`=0 with `m_valid`=1 drops `s_ready` combinationally in the same cycle.
- `busy` rises the cycle after `start` and falls the cycle after the last handshake or `abort`.
- Reset mid-frame: all outputs return to reset values asynchronously. Line buffer state is discarded.

## Structure
- Shared package `sobel_pkg`:
  - state enum (IDLE/ACTIVE/FLUSH)
  - window index constants W_TL..W_BR (0..8)
  - function `clog2`
- Sub-module `line_buffer`: PIX_W×IMG_W single-clock RAM with read-before-write at one address. Instantiated twice, or once at 2·PIX_W width.
- The controller holds the FSM, counters, window shift registers and output register.

## Test plan
- IMG_W=IMG_H=4, pixel = r*4+c, m_ready=1:
  - exactly 4 windows are emitted;
  - the first has m_x=1, m_y=1 and m_win elements {0,1,2,4,5,6,8,9,10};
  - the last has m_last=1 and elements {5,6,7,9,10,11,13,14,15};
  - `done` pulses once.
- Same frame with m_ready toggling 1,0,0,1: windows are identical and in order, and no pixel is accepted while the window is stalled.
- `abort` after pixel (2,1): state returns to IDLE, m_valid=0, no `done`. A following `start` gives a clean frame with a correct first window.
- `start` pulsed during ACTIVE: it is ignored and the window count is unchanged.
- `rst_n`=1 mid-frame: all outputs are at reset values the same cycle. A new frame after reset matches the first scenario exactly.
- IMG_W=5, IMG_H=3 with s_valid gaps of 2 cycles: 3 windows are emitted, with m_y=1 and m_x=1,2,3.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg: state encoding, window element indices and width helper shared by the frame controller
package sobel_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_e;
  localparam int W_TL = 0, W_TC = 1, W_TR = 2;
  localparam int W_ML = 3, W_MC = 4, W_MR = 5;
  localparam int W_BL = 6, W_BC = 7, W_BR = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: single-clock RAM; the combinational read returns the old word while the same address is written
module line_buffer #(
  parameter int DW    = 16,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: raster-scan sequencer building 3x3 windows from a pixel stream
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8,
  localparam int XW = clog2(IMG_W),
  localparam int YW = clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [9*PIX_W-1:0] m_win,
  output logic [XW-1:0]    m_x,
  output logic [YW-1:0]    m_y,
  output logic             m_last,
  output logic             busy,
  output logic             done
);
  state_e state_q, state_d;
  logic [XW-1:0] c_q, c_d, m_x_q, m_x_d;
  logic [YW-1:0] r_q, r_d, m_y_q, m_y_d;
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic [9*PIX_W-1:0] m_win_q, m_win_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [2*PIX_W-1:0] lb_rd;
  logic [PIX_W-1:0] lb0, lb1;
  logic acc, emit, eol, last_px, fin, go;
  assign acc = s_valid && s_ready;
  assign eol = c_q == XW'(IMG_W - 1);
  assign last_px = eol && r_q == YW'(IMG_H - 1);
  assign emit = acc && r_q >= YW'(2) && c_q >= XW'(2);
  assign fin = m_valid_q && m_ready && m_last_q;
  assign go = state_q == IDLE && start;
  assign lb0 = lb_rd[2*PIX_W-1:PIX_W];
  assign lb1 = lb_rd[PIX_W-1:0];
  // both line buffers share one RAM: upper half is row r-2, lower half row r-1
  line_buffer #(.DW(2*PIX_W), .DEPTH(IMG_W), .AW(XW)) u_lb (
    .clk(clk), .we(acc), .addr(c_q), .wdata({lb1, s_data}), .rdata(lb_rd)
  );
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = abort ? IDLE :
              go ? ACTIVE :
              (state_q == ACTIVE && acc && last_px) ? FLUSH :
              (state_q == FLUSH && fin) ? IDLE : state_q;
  end
  always_comb begin
    busy = state_q != IDLE;
    s_ready = state_q == ACTIVE && (!m_valid_q || m_ready);
    done = state_q == FLUSH && fin && !abort;
  end
  always_comb begin
    c_d = go ? '0 : acc ? (eol ? '0 : c_q + 1'b1) : c_q;
    r_d = go ? '0 : (acc && eol && r_q != YW'(IMG_H - 1)) ? r_q + 1'b1 : r_q;
    win_d = win_q;
    if (acc) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 2; c++) win_d[r*3+c] = win_q[r*3+c+1];
      win_d[W_TR] = lb0;
      win_d[W_MR] = lb1;
      win_d[W_BR] = s_data;
    end
    m_valid_d = abort ? 1'b0 : emit ? 1'b1 : (m_valid_q && m_ready) ? 1'b0 : m_valid_q;
    m_win_d = m_win_q;
    m_x_d = emit ? c_q - 1'b1 : m_x_q;
    m_y_d = emit ? r_q - 1'b1 : m_y_q;
    m_last_d = emit ? last_px : m_last_q;
    if (emit)
      for (int k = 0; k < 9; k++) m_win_d[k*PIX_W +: PIX_W] = win_d[k];
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      c_q <= '0;
      r_q <= '0;
      win_q <= '{default: '0};
      m_valid_q <= 1'b0;
      m_win_q <= '0;
      m_x_q <= '0;
      m_y_q <= '0;
      m_last_q <= 1'b0;
    end else begin
      c_q <= c_d;
      r_q <= r_d;
      win_q <= win_d;
      m_valid_q <= m_valid_d;
      m_win_q <= m_win_d;
      m_x_q <= m_x_d;
      m_y_q <= m_y_d;
      m_last_q <= m_last_d;
    end
  end
  assign m_valid = m_valid_q;
  assign m_win = m_win_q;
  assign m_x = m_x_q;
  assign m_y = m_y_q;
  assign m_last = m_last_q;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: directed and randomized frames on 4x4 and 5x3 instances against a window-list model
module tb_sobel_frame_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, abort = 1'b0, s_valid = 1'b0, m_ready = 1'b1, sel = 1'b0;
  logic [7:0] s_data = '0;
  logic s_ready4, s_ready5, m_valid4, m_valid5, m_last4, m_last5, busy4, busy5, done4, done5;
  logic [71:0] m_win4, m_win5;
  logic [1:0] m_x4, m_y4, m_y5;
  logic [2:0] m_x5;
  logic s_ready, m_valid, m_last, busy, done;
  logic [71:0] m_win;
  logic [2:0] m_x;
  logic [1:0] m_y;
  int errors = 0, checks = 0;
  typedef struct {logic [71:0] win; int x; int y; logic last;} win_t;
  win_t expq[$];
  int pix[];

  always #5 clk = ~clk;

  sobel_frame_ctrl #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .abort(abort), .s_valid(s_valid),
    .s_ready(s_ready4), .s_data(s_data), .m_valid(m_valid4), .m_ready(m_ready), .m_win(m_win4),
    .m_x(m_x4), .m_y(m_y4), .m_last(m_last4), .busy(busy4), .done(done4));
  sobel_frame_ctrl #(.IMG_W(5), .IMG_H(3), .PIX_W(8)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .abort(abort), .s_valid(s_valid),
    .s_ready(s_ready5), .s_data(s_data), .m_valid(m_valid5), .m_ready(m_ready), .m_win(m_win5),
    .m_x(m_x5), .m_y(m_y5), .m_last(m_last5), .busy(busy5), .done(done5));

  assign s_ready = sel ? s_ready5 : s_ready4;
  assign m_valid = sel ? m_valid5 : m_valid4;
  assign m_last = sel ? m_last5 : m_last4;
  assign busy = sel ? busy5 : busy4;
  assign done = sel ? done5 : done4;
  assign m_win = sel ? m_win5 : m_win4;
  assign m_x = sel ? m_x5 : {1'b0, m_x4};
  assign m_y = sel ? m_y5 : m_y4;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // every interior centre (x,y) in raster order sees the 3x3 neighbourhood of the frame
  task automatic build(input int w, input int h, input bit rnd);
    win_t e;
    pix = new[w*h];
    for (int i = 0; i < w*h; i++) pix[i] = rnd ? int'($urandom_range(0, 255)) : i;
    expq.delete();
    for (int y = 1; y <= h - 2; y++)
      for (int x = 1; x <= w - 2; x++) begin
        e.win = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) e.win[(r*3+c)*8 +: 8] = 8'(pix[(y-1+r)*w + x-1+c]);
        e.x = x;
        e.y = y;
        e.last = (y == h - 2 && x == w - 2);
        expq.push_back(e);
      end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, "_s_ready"}, s_ready, 1'b0);
    chk1({tag, "_m_valid"}, m_valid, 1'b0);
    chkw({tag, "_m_win"}, m_win, '0);
    chkw({tag, "_m_x"}, 72'(m_x), '0);
    chkw({tag, "_m_y"}, 72'(m_y), '0);
    chk1({tag, "_m_last"}, m_last, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
  endtask

  task automatic run_frame(input bit s5, input bit rnd, input int rmode, input int gap,
                           input int abort_at, input bit mid_start);
    int w, h, n, acc, wn, gc, cyc;
    bit pend, stall_prev, fin;
    logic [71:0] prev_win;
    w = s5 ? 5 : 4;
    h = s5 ? 3 : 4;
    n = w * h;
    build(w, h, rnd);
    sel = s5;
    start = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    abort = 1'b0;
    @(negedge clk);
    chk1("busy_before_start", busy, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    acc = 0; wn = 0; gc = 0; pend = 1'b0; stall_prev = 1'b0; fin = 1'b0; prev_win = '0;
    for (cyc = 1; cyc <= 3000 && !fin; cyc++) begin
      s_valid = (gc == 0) && (acc < n);
      if (acc < n) s_data = 8'(pix[acc]);
      m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 4 == 0 || cyc % 4 == 1) : 1'($urandom_range(0, 1));
      abort = (acc == abort_at);
      start = mid_start && cyc == 5;
      if (abort) begin
        s_valid = 1'b0;
        m_ready = 1'b0;
      end
      @(negedge clk);
      if (cyc == 1) chk1("busy_after_start", busy, 1'b1);
      if (pend) chk1("window_latency", m_valid, 1'b1);
      pend = 1'b0;
      if (m_valid && !m_ready) chk1("stall_blocks_s_ready", s_ready, 1'b0);
      if (stall_prev && m_valid) chkw("stall_payload_stable", m_win, prev_win);
      if (abort) begin
        chk1("abort_no_done", done, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_m_valid", m_valid, 1'b0);
        chk1("abort_s_ready", s_ready, 1'b0);
        fin = 1'b1;
      end else begin
        if (m_valid && m_ready) begin
          if (wn < expq.size()) begin
            chkw("win_data", m_win, expq[wn].win);
            chkw("win_x", 72'(m_x), 72'(expq[wn].x));
            chkw("win_y", 72'(m_y), 72'(expq[wn].y));
            chk1("win_last", m_last, expq[wn].last);
          end
          wn++;
        end
        if (s_valid && s_ready) begin
          if (acc / w >= 2 && acc % w >= 2) pend = 1'b1;
          acc++;
          gc = gap;
        end else if (gc > 0) gc--;
        if (done) begin
          chkw("done_after_all_windows", 72'(wn), 72'(expq.size()));
          if (rmode == 0 && gap == 0) chkw("done_cycle", 72'(cyc), 72'(n + 1));
          fin = 1'b1;
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_win = m_win;
      if (!fin) begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    assert (fin) else begin
      errors++;
      $error("FAIL frame_timeout observed=%0d windows expected=%0d", wn, expq.size());
    end
    if (abort_at < 0 && fin) begin
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk1("busy_falls", busy, 1'b0);
      chk1("done_once", done, 1'b0);
      chk1("idle_m_valid", m_valid, 1'b0);
    end
    start = 1'b0;
    abort = 1'b0;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sel = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    run_frame(1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_frame(1'b0, 1'b0, 1, 0, -1, 1'b0);
    run_frame(1'b0, 1'b0, 0, 0, 10, 1'b0);
    run_frame(1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_frame(1'b0, 1'b1, 0, 0, -1, 1'b1);
    run_frame(1'b0, 1'b1, 0, 0, 11, 1'b0);
    sel = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk1("start_abort_same_cycle", busy, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_data = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    chk1("pre_reset_m_valid", m_valid, 1'b1);
    #2;
    rst_n = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    run_frame(1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_frame(1'b1, 1'b0, 0, 2, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_frame(1'b0, 1'b1, 2, i, -1, 1'b0);
      run_frame(1'b1, 1'b1, 2, 1, -1, 1'b0);
    end
    run_frame(1'b1, 1'b1, 2, 0, 13, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
